mix_columns_unit: RTL and testbench
===================================

MIX_COLUMNS_UNIT -- requirements
Module: mix_columns_unit

Interface
REQ-001 Parameter NUM_COLS, default 4, meaning number of 32-bit state columns per transaction; legal range 1..4.
REQ-002 Parameter INVERSE_EN, default 1, meaning InvMixColumns support is present (1) or absent (0).
REQ-003 pi_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 pi_rst  input  1  reset, asynchronous, active-high.
REQ-005 pi_valid  input  1  input transaction valid.
REQ-006 po_ready  output  1  unit can accept a transaction.
REQ-007 pi_data  input  32*NUM_COLS  state columns; column 0 in the MSBs; within a column, byte a0 in bits [31:24], a3 in [7:0].
REQ-008 pi_inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with pi_data.
REQ-009 po_valid  output  1  result valid.
REQ-010 pi_ready  input  1  downstream accepts result.
REQ-011 po_data  output  32*NUM_COLS  transformed state, same packing as pi_data.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; po_ready = (state == IDLE); po_valid = (state == DONE).
REQ-013 IDLE: pi_valid=1 on an edge -> capture pi_data, pi_inverse, clear column counter, go CALC.
REQ-014 CALC: each cycle transform column[counter] into the result register and increment counter; after column NUM_COLS-1 go DONE; counter width SHALL be 2 bits, no wrap beyond NUM_COLS-1.
REQ-015 Latency: po_valid SHALL rise exactly NUM_COLS cycles after the accepting edge.
REQ-016 DONE: po_data and po_valid SHALL hold stable until pi_ready=1 on an edge, then go IDLE; pi_ready in the same cycle po_valid rises completes the transfer at that edge.
REQ-017 pi_valid while not IDLE SHALL be ignored (no capture, no state change); back-to-back throughput is one transaction per NUM_COLS+2 cycles minimum.
REQ-018 Forward: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-019 Inverse: b0=14a0^11a1^13a2^9a3, rotating the coefficient row by one byte per output as in forward.
REQ-020 GF(2^8) multiply SHALL use reduction polynomial 0x11B (xtime: shift left, XOR 0x1B when bit 7 was set); all intermediate values 8 bits.
REQ-021 INVERSE_EN=0: pi_inverse ignored, forward always; inverse multipliers not synthesised.
REQ-022 po_data SHALL read 0 outside DONE.

Reset
REQ-023 pi_rst=1 SHALL immediately force state IDLE, counter 0, captured data/mode and result register 0, po_valid 0, po_ready 1, regardless of clock.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the transaction; no partial result is ever presented.
REQ-025 First acceptance is possible on the first rising edge after pi_rst deasserts.

Structure
REQ-026 Shared package SHALL hold: reduction constant 0x1B, forward coefficient row {2,3,1,1}, inverse row {14,11,13,9}, FSM state encoding.
REQ-027 One sub-module gf_mul_const SHALL multiply one byte by a coefficient from {1,2,3,9,11,13,14} combinationally; the unit instantiates 16 (one column per cycle).
REQ-028 Column select and result write-back indexed by the counter; no other sub-modules.

Verification
REQ-029 NUM_COLS=4, forward, columns db135345, f20a225c, 01010101, c6c6c6c6 -> po_data 8e4da1bc 9fdc589d 01010101 c6c6c6c6, po_valid 4 cycles after accept.
REQ-030 Inverse with input 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 -> db135345 f20a225c d4d4d4d5 2d26314c.
REQ-031 pi_ready held 0 for 10 cycles in DONE -> po_data/po_valid stable, po_ready 0, new pi_valid ignored; pi_ready=1 -> IDLE next cycle.
REQ-032 pi_rst pulsed asynchronously (between edges) during CALC column 2 -> po_valid 0, po_ready 1, po_data 0 immediately; no result emitted.
REQ-033 NUM_COLS=1, INVERSE_EN=0, input d4d4d4d5 with pi_inverse=1 -> d5d5d7d6 after 1 cycle.
REQ-034 Randomised back-to-back traffic with random pi_ready against a reference model; forward-then-inverse round trip returns the original state.

Source files
------------

// File: rtl/mix_columns_unit_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the MixColumns unit.
package mix_columns_unit_pkg;

    localparam logic [7:0]  GF_RED  = 8'h1B;
    localparam logic [15:0] FWD_ROW = 16'h2311;   // {2,3,1,1}
    localparam logic [15:0] INV_ROW = 16'hEBD9;   // {14,11,13,9}

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    function automatic logic [3:0] row_coef(input logic [15:0] row, input int k);
        return row[15-4*k -: 4];
    endfunction

endpackage

// File: rtl/mix_columns_unit_gf_mul_const.sv
// Combinational GF(2^8) multiply of one byte by a 4-bit coefficient (1,2,3,9,11,13,14).
module gf_mul_const
    import mix_columns_unit_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [3:0] coef_i,
    output logic [7:0] p_o
);

    logic [7:0] x2, x4, x8;

    assign x2 = xtime(a_i);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    // Coefficient bits select the power-of-two partial products.
    assign p_o = ({8{coef_i[0]}} & a_i) ^
                 ({8{coef_i[1]}} & x2)  ^
                 ({8{coef_i[2]}} & x4)  ^
                 ({8{coef_i[3]}} & x8);

endmodule

// File: rtl/mix_columns_unit.sv
// AES (Inv)MixColumns over NUM_COLS state columns, one column transformed per cycle.
// state | meaning
// IDLE  | ready for a new state; po_ready high
// CALC  | transforming column cnt_q into the result register
// DONE  | result presented until pi_ready
module mix_columns_unit
    import mix_columns_unit_pkg::*;
#(
    parameter int NUM_COLS   = 4,
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic                  pi_clk,
    input  logic                  pi_rst,
    input  logic                  pi_valid,
    output logic                  po_ready,
    input  logic [32*NUM_COLS-1:0] pi_data,
    input  logic                  pi_inverse,
    output logic                  po_valid,
    input  logic                  pi_ready,
    output logic [32*NUM_COLS-1:0] po_data
);

    localparam int W = 32 * NUM_COLS;

    state_e                 state_q;
    logic [1:0]             cnt_q;
    logic [W-1:0]           data_q;
    logic [W-1:0]           res_q;
    logic                   inv_q;
    logic [31:0]            col_in;
    logic [31:0]            col_out;
    logic [3:0][3:0][7:0]   prod;

    always_comb begin
        col_in = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (cnt_q == 2'(c)) col_in = data_q[W-32*(c+1) +: 32];
        end
    end

    // Coefficients are elaboration constants; with INVERSE_EN=0 the inverse
    // branch folds away and only the forward multipliers remain.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_byte
            localparam logic [3:0] CF = row_coef(FWD_ROW, (j - r + 4) % 4);
            localparam logic [3:0] CI = row_coef(INV_ROW, (j - r + 4) % 4);
            logic [3:0] coef;

            assign coef = (INVERSE_EN && inv_q) ? CI : CF;

            gf_mul_const u_mul (
                .a_i   (col_in[31-8*j -: 8]),
                .coef_i(coef),
                .p_o   (prod[r][j])
            );
        end
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                col_out[8*(3-r) +: 8] = col_out[8*(3-r) +: 8] ^ prod[r][j];
            end
        end
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            inv_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pi_valid) begin
                        data_q  <= pi_data;
                        inv_q   <= INVERSE_EN & pi_inverse;
                        cnt_q   <= '0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (cnt_q == 2'(c)) res_q[W-32*(c+1) +: 32] <= col_out;
                    end
                    if (cnt_q == 2'(NUM_COLS - 1)) state_q <= ST_DONE;
                    else                           cnt_q   <= cnt_q + 2'd1;
                end
                ST_DONE: begin
                    if (pi_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign po_ready = (state_q == ST_IDLE);
    assign po_valid = (state_q == ST_DONE);
    assign po_data  = (state_q == ST_DONE) ? res_q : '0;

endmodule

// File: tb/tb_mix_columns_unit.sv
// Directed and model-checked stimulus for mix_columns_unit (4-column and 1-column forward-only builds).
module tb_mix_columns_unit;

    logic         clk = 1'b0;
    logic         rst, rst1;
    logic         valid, ready_o, vout, rdy_in, inv;
    logic [127:0] data, dout;
    logic         valid1, ready1_o, vout1, rdy_in1, inv1;
    logic [31:0]  data1, dout1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mix_columns_unit #(.NUM_COLS(4), .INVERSE_EN(1'b1)) dut (
        .pi_clk(clk), .pi_rst(rst), .pi_valid(valid), .po_ready(ready_o),
        .pi_data(data), .pi_inverse(inv), .po_valid(vout), .pi_ready(rdy_in),
        .po_data(dout)
    );

    mix_columns_unit #(.NUM_COLS(1), .INVERSE_EN(1'b0)) dut1 (
        .pi_clk(clk), .pi_rst(rst1), .pi_valid(valid1), .po_ready(ready1_o),
        .pi_data(data1), .pi_inverse(inv1), .po_valid(vout1), .pi_ready(rdy_in1),
        .po_data(dout1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic iv);
        int cf[4];
        logic [7:0] a[4];
        logic [31:0] o;
        if (iv) cf = '{14, 11, 13, 9};
        else    cf = '{2, 3, 1, 1};
        for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                o[31-8*r -: 8] = o[31-8*r -: 8] ^ gmul(a[j], 8'(cf[(j - r + 4) % 4]));
        return o;
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] d, input logic iv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(d[127-32*c -: 32], iv);
        return o;
    endfunction

    // Accept on the next edge (unit must be idle), then wait for po_valid.
    task automatic run_txn(input logic [127:0] d, input logic iv, input logic rdy_early,
                           output logic [127:0] res, output int lat);
        data = d; inv = iv; valid = 1'b1; rdy_in = rdy_early;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        while (!vout && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dout;
    endtask

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    initial begin
        logic [127:0] res, res2, x, exp_r;
        int lat, saw;
        logic got, done, xfer;

        rst = 1'b1; rst1 = 1'b1;
        valid = 1'b0; rdy_in = 1'b0; inv = 1'b0; data = '0;
        valid1 = 1'b0; rdy_in1 = 1'b0; inv1 = 1'b0; data1 = '0;
        #2;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", vout, 0);
        chk("rst_data", dout, 0);
        #20;
        rst = 1'b0; rst1 = 1'b0;

        // First edge after reset release accepts.
        run_txn(FWD_IN, 1'b0, 1'b0, res, lat);
        chk("fwd_latency", lat, 4);
        chk("fwd_data", res, FWD_OUT);
        chk("fwd_ready_low", ready_o, 0);

        for (int i = 0; i < 10; i++) begin
            valid = 1'b1; data = INV_IN; inv = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", vout, 1);
            chk("hold_data", dout, FWD_OUT);
            chk("hold_ready", ready_o, 0);
        end
        valid = 1'b0; rdy_in = 1'b1;
        @(posedge clk); #1;
        rdy_in = 1'b0;
        chk("release_ready", ready_o, 1);
        chk("release_valid", vout, 0);
        chk("release_data", dout, 0);
        @(posedge clk); #1;
        chk("no_stale_accept", ready_o, 1);

        // pi_ready already high when po_valid rises.
        run_txn(INV_IN, 1'b1, 1'b1, res, lat);
        chk("inv_latency", lat, 4);
        chk("inv_data", res, INV_OUT);
        @(posedge clk); #1;
        chk("same_cycle_xfer", ready_o, 1);
        rdy_in = 1'b0;

        // Async reset during CALC column 2.
        data = FWD_IN; inv = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2; rst = 1'b1; #1;
        chk("midrst_valid", vout, 0);
        chk("midrst_ready", ready_o, 1);
        chk("midrst_data", dout, 0);
        #1; rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (vout) saw = 1;
        end
        chk("midrst_no_result", saw, 0);

        // Round trip.
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        run_txn(x, 1'b0, 1'b1, res, lat);
        chk("rt_fwd", res, mix_state(x, 1'b0));
        @(posedge clk); #1;
        run_txn(res, 1'b1, 1'b1, res2, lat);
        chk("rt_back", res2, x);
        @(posedge clk); #1;
        rdy_in = 1'b0;

        // Back-to-back traffic with random pi_ready.
        for (int k = 0; k < 12; k++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv = 1'($urandom_range(0, 1));
            exp_r = mix_state(x, inv);
            chk("rand_idle", ready_o, 1);
            data = x; valid = 1'b1; rdy_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            valid = 1'b0;
            got = 1'b0; done = 1'b0;
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                if (vout && !got) begin
                    chk("rand_data", dout, exp_r);
                    got = 1'b1;
                end
                rdy_in = 1'($urandom_range(0, 1));
                xfer = vout && rdy_in;
                @(posedge clk); #1;
                if (xfer) done = 1'b1;
            end
            chk("rand_done", done, 1);
            rdy_in = 1'b0;
        end

        // Single-column forward-only build ignores pi_inverse.
        data1 = 32'hd4d4d4d5; inv1 = 1'b1; valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        chk("c1_calc", vout1, 0);
        @(posedge clk); #1;
        chk("c1_valid", vout1, 1);
        chk("c1_data", dout1, 32'hd5d5d7d6);
        rdy_in1 = 1'b1;
        @(posedge clk); #1;
        rdy_in1 = 1'b0;
        chk("c1_idle", ready1_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
